booth_seq: RTL and testbench

BOOTH_SEQ -- requirements
Module: booth_seq

---
 rtl/booth_seq.sv | 106 ++++++++++
 tb/tb_booth_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// One operand pair in flight at a time; product held registered until accepted.
module booth_seq #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic [WIDTH:0]       sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sum     = a_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // A and M carry one extra sign bit so -2^(WIDTH-1) never overflows
          m_d     = {in1[WIDTH-1], in1};
          q_d     = in2;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        unique case ({q_q[0], qm1_q})
          2'b01:   sum = a_q + m_q;
          2'b10:   sum = a_q - m_q;
          default: sum = a_q;
        endcase
        a_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = {a_d[WIDTH-1:0], q_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_booth_seq.sv
// Directed and exhaustive checks of booth_seq at WIDTH = 6 against hand-computed
// and integer-multiply reference products.
module tb_booth_seq;

  localparam int W = 6;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in1;
  logic [W-1:0]    in2;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out;
  logic            busy;

  int total;
  int bad;

  booth_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
    end
  endtask

  task automatic issue(input int a, input int b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("issue_ready", int'(in_ready), 1);
    in1      = W'(a);
    in2      = W'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_ok);
    lat     = 0;
    busy_ok = 1;
    while (!out_valid && lat < 30) begin
      if (!busy) busy_ok = 0;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input int a, input int b, input int exp);
    int lat;
    int bok;
    out_ready = 1'b1;
    issue(a, b);
    wait_done(lat, bok);
    check("latency", lat, W);
    check("busy_calc", bok, 1);
    check("product", int'(out), exp);
    check("busy_done", int'(busy), 1);
    tick();
    check("valid_drop", int'(out_valid), 0);
    check("out_hold", int'(out), exp);
  endtask

  initial begin
    int lat;
    int bok;
    int seen;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;

    vecs[0] = '{a:  5, b:  -3, exp: 'hFF1};
    vecs[1] = '{a: -32, b: -32, exp: 'h400};
    vecs[2] = '{a: -32, b:  31, exp: 'hC20};
    vecs[3] = '{a: 31, b:  31, exp: 'h3C1};
    vecs[4] = '{a:  0, b: -17, exp: 'h000};
    vecs[5] = '{a:  1, b:   1, exp: 'h001};
    vecs[6] = '{a: -1, b:  -1, exp: 'h001};
    vecs[7] = '{a: -1, b:  31, exp: 'hFE1};
    vecs[8] = '{a:  7, b:  -8, exp: 'hFC8};
    vecs[9] = '{a:  2, b:   3, exp: 'h006};

    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out", int'(out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Backpressure: hold the product for four cycles before accepting it.
    out_ready = 1'b0;
    issue(-5, 6);
    wait_done(lat, bok);
    check("bp_latency", lat, W);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_out", int'(out), 'hFE2);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", int'(in_ready), 1);
    check("bp_valid_after", int'(out_valid), 0);

    // Inputs pulsed mid-calculation must not disturb the operation in flight.
    issue(5, -3);
    tick();
    in1      = W'(7);
    in2      = W'(7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat, bok);
    check("iso_latency", lat, W - 2);
    check("iso_product", int'(out), 'hFF1);
    tick();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || busy) seen = 1;
      tick();
    end
    check("iso_no_second", seen, 0);

    // Asynchronous reset in the third CALC cycle discards the product.
    issue(9, 9);
    tick();
    tick();
    check("abort_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out", int'(out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    check("abort_never_valid", seen, 0);
    run_op(2, 3, 'h006);

    // Exhaustive back-to-back sweep against integer multiplication.
    out_ready = 1'b1;
    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        issue(a, b);
        wait_done(lat, bok);
        check("ex_latency", lat, W);
        check("ex_product", int'(out), (a * b) & 'hFFF);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
